piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8: number of data bits per frame, legal range 1..32.
REQ-002 Parameter CLKS_PER_BIT, default 4: i_clk cycles per serial bit, legal range 1..65535.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_data  input  WIDTH  parallel word to transmit; sampled only on acceptance.
REQ-006 i_valid  input  1  upstream asserts when i_data holds a word to send.
REQ-007 o_ready  output  1  high only in IDLE; acceptance = i_valid && o_ready on a rising edge.
REQ-008 o_sdata  output  1  serial line; idles high.
REQ-009 o_sdata_n  output  1  registered complement of o_sdata at all times.
REQ-010 o_busy  output  1  high in every state except IDLE.
REQ-011 o_done  output  1  one-cycle pulse marking completion of a frame.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY (present only with PISO_TX_PARITY_EN), and STOP.
REQ-013 Acceptance in IDLE SHALL capture i_data into the shift register, load the bit counter with WIDTH, and enter START on the same edge.
REQ-014 START SHALL drive o_sdata=0 beginning in the cycle after acceptance, so latency from acceptance to line low is 1 cycle.
REQ-015 Each of START, each DATA bit, PARITY, and STOP SHALL hold o_sdata for exactly CLKS_PER_BIT cycles, timed by a divider that reloads on every bit boundary.
REQ-016 DATA SHALL shift out WIDTH bits LSB first, then go to PARITY if present, else to STOP.
REQ-017 STOP SHALL drive o_sdata=1; on its last cycle o_done SHALL be 1, and the next state SHALL be IDLE with o_ready=1.
REQ-018 Total frame length SHALL be (WIDTH+2)*CLKS_PER_BIT cycles without parity and (WIDTH+3)*CLKS_PER_BIT cycles with parity.
REQ-019 i_valid and i_data SHALL be ignored whenever o_ready=0; changes to i_data mid-frame SHALL NOT affect the line.
REQ-020 Back-to-back transfers: if i_valid is held high, the next word SHALL be accepted in the first IDLE cycle after o_done, giving exactly one idle-high cycle between frames.
REQ-021 If i_valid drops before acceptance, no frame SHALL start; the line SHALL stay high.
REQ-022 With CLKS_PER_BIT=1, every bit SHALL last exactly one cycle, with no skipped or doubled bits.
REQ-023 All outputs SHALL be registered, with no combinational path from i_valid or i_data to any output.

Reset
REQ-024 Assertion of i_rst_n=0 SHALL immediately, without waiting for a clock, force: state=IDLE, o_sdata=1, o_sdata_n=0, o_ready=1, o_busy=0, o_done=0, divider=0, bit counter=0, shift register=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no o_done pulse; after deassertion the first edge with i_valid=1 SHALL start a fresh frame.
REQ-026 Deassertion SHALL take effect at the first rising edge at which i_rst_n is sampled high.

Configuration
REQ-027 Macro PISO_TX_PARITY_EN defined: the PARITY state is compiled in and sends the even-parity bit (XOR of all captured data bits) for CLKS_PER_BIT cycles between DATA and STOP.
REQ-028 Macro PISO_TX_PARITY_EN undefined: no PARITY state and no parity logic exist; DATA goes directly to STOP.

Verification
REQ-029 Default parameters, no parity, one-cycle i_valid with i_data=0xA5 -> line reads 0,1,0,1,0,0,1,0,1,1, each value 4 cycles; o_done pulses 40 cycles after acceptance.
REQ-030 Parity enabled, i_data=0xA5 then 0x07 -> parity bit 0 for 0xA5 and 1 for 0x07; each frame is 44 cycles.
REQ-031 i_valid held high with words 0x01, 0x02, 0x03 -> three frames, each separated by exactly one idle-high cycle; o_ready high only in those gap cycles.
REQ-032 Reset pulsed during the 3rd data bit of 0xFF -> o_sdata=1 and o_sdata_n=0 immediately; no o_done; the next accepted 0x3C transmits correctly.
REQ-033 CLKS_PER_BIT=1, WIDTH=4, i_data=0x9 -> line reads 0,1,0,0,1,1 on consecutive cycles; o_done in cycle 6.
REQ-034 i_data toggled randomly while o_busy=1 -> the transmitted bits match the word captured at acceptance.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter (start bit, WIDTH data bits LSB first, stop bit).
// Define PISO_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module piso_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_sdata,
  output logic             o_sdata_n,
  output logic             o_busy,
  output logic             o_done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;

`ifdef PISO_TX_PARITY_EN
  logic par_bit;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      o_sdata   <= 1'b1;
      o_sdata_n <= 1'b0;
      o_ready   <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      div       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
`ifdef PISO_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            shreg     <= i_data;
            bit_cnt   <= CNT_FULL;
            div       <= DIV_LAST;
            state     <= START;
            o_sdata   <= 1'b0;
            o_sdata_n <= 1'b1;
            o_ready   <= 1'b0;
            o_busy    <= 1'b1;
`ifdef PISO_TX_PARITY_EN
            par_bit   <= even_parity(i_data);
`endif
          end
        end
        default: begin
          if (div != '0) begin
            div    <= div - DIV_ONE;
            o_done <= (state == STOP) && (div == DIV_ONE);
          end else begin
            div <= DIV_LAST;
            case (state)
              // START leaves with bit_cnt == WIDTH, so it shares the "next data bit" path
              START, DATA: begin
                if (bit_cnt != '0) begin
                  state     <= DATA;
                  o_sdata   <= shreg[0];
                  o_sdata_n <= ~shreg[0];
                  shreg     <= shreg >> 1;
                  bit_cnt   <= bit_cnt - CNT_ONE;
                end else begin
`ifdef PISO_TX_PARITY_EN
                  state     <= PARITY;
                  o_sdata   <= par_bit;
                  o_sdata_n <= ~par_bit;
`else
                  state     <= STOP;
                  o_sdata   <= 1'b1;
                  o_sdata_n <= 1'b0;
                  o_done    <= (DIV_LAST == '0);
`endif
                end
              end
`ifdef PISO_TX_PARITY_EN
              PARITY: begin
                state     <= STOP;
                o_sdata   <= 1'b1;
                o_sdata_n <= 1'b0;
                o_done    <= (DIV_LAST == '0);
              end
`endif
              STOP: begin
                state   <= IDLE;
                div     <= '0;
                o_ready <= 1'b1;
                o_busy  <= 1'b0;
              end
              default: begin
                state     <= IDLE;
                div       <= '0;
                o_sdata   <= 1'b1;
                o_sdata_n <= 1'b0;
                o_ready   <= 1'b1;
                o_busy    <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a default instance (WIDTH=8, CLKS_PER_BIT=4) and a fast one (WIDTH=4, CLKS_PER_BIT=1).
// Expected line waveforms come from a frame model built from the bit-level framing rules.
module tb_piso_tx;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int W1 = 4;
  localparam int C1 = 1;

`ifdef PISO_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b1;
  logic [W-1:0]  data  = '0;
  logic          valid = 1'b0;
  logic          ready, sdata, sdata_n, busy, done;
  logic [W1-1:0] data1  = '0;
  logic          valid1 = 1'b0;
  logic          ready1, sdata1, sdata1_n, busy1, done1;

  int checks   = 0;
  int failures = 0;

  piso_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_sdata(sdata), .o_sdata_n(sdata_n), .o_busy(busy), .o_done(done)
  );

  piso_tx #(.WIDTH(W1), .CLKS_PER_BIT(C1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data1), .i_valid(valid1),
    .o_ready(ready1), .o_sdata(sdata1), .o_sdata_n(sdata1_n), .o_busy(busy1), .o_done(done1)
  );

  // Reference frame: line level for every clock cycle of one frame.
  bit exp_q[$];

  task automatic build_frame(input logic [31:0] d, input int width, input int cpb);
    bit ones;
    ones = 1'b0;
    exp_q.delete();
    for (int c = 0; c < cpb; c++) exp_q.push_back(1'b0);
    for (int i = 0; i < width; i++) begin
      ones ^= d[i];
      for (int c = 0; c < cpb; c++) exp_q.push_back(d[i]);
    end
    if (PAR) for (int c = 0; c < cpb; c++) exp_q.push_back(ones);
    for (int c = 0; c < cpb; c++) exp_q.push_back(1'b1);
  endtask

  // One-cycle request; returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] d);
    @(negedge clk);
    data  = d;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic launch1(input logic [W1-1:0] d);
    @(negedge clk);
    data1  = d;
    valid1 = 1'b1;
    @(posedge clk);
    #1 valid1 = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sdata !== 1'b1 || sdata_n !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got sdata=%b sdata_n=%b ready=%b busy=%b done=%b exp 1 0 1 0 0",
               sdata, sdata_n, ready, busy, done);
    end
    checks++;
    if (sdata1 !== 1'b1 || sdata1_n !== 1'b0 || ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_fast got sdata=%b sdata_n=%b ready=%b busy=%b done=%b exp 1 0 1 0 0",
               sdata1, sdata1_n, ready1, busy1, done1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sdata !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got sdata=%b ready=%b busy=%b exp 1 1 0", sdata, ready, busy);
    end
  endtask

  task automatic test_frames();
    logic [W-1:0] words [8];
    int n;
    words[0] = 8'hA5;
    words[1] = 8'h07;
    for (int i = 2; i < 8; i++) words[i] = W'($urandom);
    for (int j = 0; j < 8; j++) begin
      build_frame(32'(words[j]), W, C);
      n = exp_q.size();
      launch(words[j]);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        checks++;
        if (sdata !== exp_q[k-1]) begin
          failures++;
          $display("FAIL frame_sdata word=%h cyc=%0d got=%b exp=%b", words[j], k, sdata, exp_q[k-1]);
        end
        checks++;
        if (sdata_n !== ~exp_q[k-1]) begin
          failures++;
          $display("FAIL frame_sdata_n word=%h cyc=%0d got=%b exp=%b", words[j], k, sdata_n, ~exp_q[k-1]);
        end
        checks++;
        if (done !== (k == n)) begin
          failures++;
          $display("FAIL frame_done word=%h cyc=%0d got=%b exp=%b", words[j], k, done, (k == n));
        end
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
          failures++;
          $display("FAIL frame_busy word=%h cyc=%0d got busy=%b ready=%b exp 1 0", words[j], k, busy, ready);
        end
      end
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || sdata !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL frame_end word=%h got ready=%b busy=%b sdata=%b done=%b exp 1 0 1 0",
                 words[j], ready, busy, sdata, done);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [3];
    int n;
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;
    @(negedge clk);
    data  = words[0];
    valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      build_frame(32'(words[j]), W, C);
      n = exp_q.size();
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        if (k == 1 && j < 2) data = words[j+1];
        checks++;
        if (sdata !== exp_q[k-1]) begin
          failures++;
          $display("FAIL b2b_sdata word=%h cyc=%0d got=%b exp=%b", words[j], k, sdata, exp_q[k-1]);
        end
        checks++;
        if (ready !== 1'b0 || done !== (k == n)) begin
          failures++;
          $display("FAIL b2b_ctrl word=%h cyc=%0d got ready=%b done=%b exp 0 %b",
                   words[j], k, ready, done, (k == n));
        end
      end
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || sdata !== 1'b1) begin
        failures++;
        $display("FAIL b2b_gap word=%h got ready=%b busy=%b sdata=%b exp 1 0 1", words[j], ready, busy, sdata);
      end
      if (j == 2) valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || sdata !== 1'b1) begin
      failures++;
      $display("FAIL b2b_after got ready=%b busy=%b sdata=%b exp 1 0 1", ready, busy, sdata);
    end
  endtask

  task automatic test_valid_drop();
    @(negedge clk);
    data  = W'($urandom);
    valid = 1'b1;
    #2 valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (sdata !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL valid_drop cyc=%0d got sdata=%b ready=%b busy=%b exp 1 1 0", k, sdata, ready, busy);
      end
    end
  endtask

  task automatic test_data_toggle();
    logic [W-1:0] w;
    int n;
    for (int t = 0; t < 4; t++) begin
      w = W'($urandom);
      build_frame(32'(w), W, C);
      n = exp_q.size();
      launch(w);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        checks++;
        if (sdata !== exp_q[k-1] || done !== (k == n)) begin
          failures++;
          $display("FAIL toggle word=%h cyc=%0d got sdata=%b done=%b exp %b %b",
                   w, k, sdata, done, exp_q[k-1], (k == n));
        end
        data = W'($urandom);
        valid = (k < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || sdata !== 1'b1) begin
        failures++;
        $display("FAIL toggle_end word=%h got ready=%b sdata=%b exp 1 1", w, ready, sdata);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    launch(8'hFF);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sdata !== 1'b1 || sdata_n !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async got sdata=%b sdata_n=%b ready=%b busy=%b done=%b exp 1 0 1 0 0",
               sdata, sdata_n, ready, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || sdata !== 1'b1) begin
        failures++;
        $display("FAIL midreset_quiet cyc=%0d got done=%b sdata=%b exp 0 1", k, done, sdata);
      end
    end
    build_frame(32'h3C, W, C);
    n = exp_q.size();
    launch(8'h3C);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      checks++;
      if (sdata !== exp_q[k-1] || sdata_n !== ~exp_q[k-1] || done !== (k == n)) begin
        failures++;
        $display("FAIL midreset_3c cyc=%0d got sdata=%b sdata_n=%b done=%b exp %b %b %b",
                 k, sdata, sdata_n, done, exp_q[k-1], ~exp_q[k-1], (k == n));
      end
    end
  endtask

  task automatic test_cpb1();
    logic [W1-1:0] words [4];
    int n;
    words[0] = 4'h9;
    for (int i = 1; i < 4; i++) words[i] = W1'($urandom);
    for (int j = 0; j < 4; j++) begin
      build_frame(32'(words[j]), W1, C1);
      n = exp_q.size();
      launch1(words[j]);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        checks++;
        if (sdata1 !== exp_q[k-1] || sdata1_n !== ~exp_q[k-1]) begin
          failures++;
          $display("FAIL cpb1_sdata word=%h cyc=%0d got=%b/%b exp=%b", words[j], k, sdata1, sdata1_n, exp_q[k-1]);
        end
        checks++;
        if (done1 !== (k == n) || busy1 !== 1'b1) begin
          failures++;
          $display("FAIL cpb1_ctrl word=%h cyc=%0d got done=%b busy=%b exp %b 1", words[j], k, done1, busy1, (k == n));
        end
      end
      @(negedge clk);
      checks++;
      if (ready1 !== 1'b1 || busy1 !== 1'b0 || sdata1 !== 1'b1 || done1 !== 1'b0) begin
        failures++;
        $display("FAIL cpb1_end word=%h got ready=%b busy=%b sdata=%b done=%b exp 1 0 1 0",
                 words[j], ready1, busy1, sdata1, done1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_valid_drop();
    test_data_toggle();
    test_reset_midframe();
    test_cpb1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
